inst_fetch: RTL and testbench

- Instruction-fetch stage of the 5-stage RV32I pipeline.
- Directly upstream of the decoder: it feeds the instruction word and its PC into the ID stage.
- Owns the PC register, drives the synchronous instruction ROM, applies redirects from ID (predicted-taken branch/JAL) and EX (mispredict/JALR), honours hazard stalls, and freezes fetch on ECALL.

---
 rtl/inst_fetch_pkg.sv | 20 ++
 rtl/inst_fetch_pc_gen.sv | 48 ++++
 rtl/inst_fetch.sv | 121 ++++++++++++
 tb/tb_inst_fetch.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/inst_fetch_pkg.sv
// ============================================================================
// inst_fetch_pkg : shared constants and state type for the RV32I fetch stage
// Rev 1.0
// ============================================================================
`default_nettype none

package inst_fetch_pkg;

  localparam logic [31:0] NOP_INST         = 32'h0000_0013;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } fetch_state_t;

endpackage

`default_nettype wire

// File: rtl/inst_fetch_pc_gen.sv
// ============================================================================
// inst_fetch_pc_gen : next-PC priority mux with target alignment and +4 wrap
// Rev 1.0
// ============================================================================
`default_nettype none

module inst_fetch_pc_gen
  import inst_fetch_pkg::*;
#(
  parameter int unsigned       XLEN     = 32,
  parameter logic [XLEN-1:0]   RESET_PC = DEFAULT_RESET_PC
) (
  input  fetch_state_t         state_i,
  input  logic [XLEN-1:0]      pc_i,
  input  logic                 stall_i,
  input  logic                 id_redirect_i,
  input  logic [XLEN-1:0]      id_target_i,
  input  logic                 ex_redirect_i,
  input  logic [XLEN-1:0]      ex_target_i,
  output logic [XLEN-1:0]      next_pc_o
);

  localparam logic [XLEN-1:0] PC_STEP = XLEN'(4);

  logic [XLEN-1:0] w_id_tgt;
  logic [XLEN-1:0] w_ex_tgt;

  assign w_id_tgt = {id_target_i[XLEN-1:2], 2'b00};
  assign w_ex_tgt = {ex_target_i[XLEN-1:2], 2'b00};

  // EX outranks stall: the EX instruction is older than whatever ID holds.
  always_comb begin
    next_pc_o = pc_i + PC_STEP;
    unique case (state_i)
      BOOT: next_pc_o = RESET_PC;
      HALT: next_pc_o = ex_redirect_i ? w_ex_tgt : pc_i;
      default: begin
        if (ex_redirect_i)      next_pc_o = w_ex_tgt;
        else if (stall_i)       next_pc_o = pc_i;
        else if (id_redirect_i) next_pc_o = w_id_tgt;
        else                    next_pc_o = pc_i + PC_STEP;
      end
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/inst_fetch.sv
// ============================================================================
// inst_fetch : RV32I IF stage - PC register, ROM addressing, redirects, ECALL halt
// Optional perf counters enabled by defining FETCH_PERF_EN.   Rev 1.0
// ============================================================================
`default_nettype none

module inst_fetch
  import inst_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
  parameter int unsigned XLEN     = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall_i,
  input  logic              id_redirect_i,
  input  logic [XLEN-1:0]   id_target_i,
  input  logic              id_excp_i,
  input  logic              ex_redirect_i,
  input  logic [XLEN-1:0]   ex_target_i,
  output logic [XLEN-1:0]   imem_addr_o,
  input  logic [XLEN-1:0]   imem_rdata_i,
  output logic [XLEN-1:0]   if_inst_o,
  output logic [XLEN-1:0]   if_pc_o,
  output logic              if_valid_o,
  output logic              halted_o,
  output logic [XLEN-1:0]   epc_o
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]       perf_fetch_o,
  output logic [31:0]       perf_redirect_o
`endif
);

  fetch_state_t    state_q, state_d;
  logic [XLEN-1:0] pc_q;
  logic [XLEN-1:0] epc_q, epc_d;
  logic [XLEN-1:0] w_next_pc;

  inst_fetch_pc_gen #(
    .XLEN     (XLEN),
    .RESET_PC (XLEN'(RESET_PC))
  ) u_pc_gen (
    .state_i       (state_q),
    .pc_i          (pc_q),
    .stall_i       (stall_i),
    .id_redirect_i (id_redirect_i),
    .id_target_i   (id_target_i),
    .ex_redirect_i (ex_redirect_i),
    .ex_target_i   (ex_target_i),
    .next_pc_o     (w_next_pc)
  );

  // ROM latches this address, so its data lines up with pc_q next cycle.
  assign imem_addr_o = w_next_pc;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= BOOT;
      pc_q    <= XLEN'(RESET_PC);
      epc_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= w_next_pc;
      epc_q   <= epc_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    epc_d      = epc_q;
    if_valid_o = 1'b0;
    if_inst_o  = XLEN'(NOP_INST);
    unique case (state_q)
      BOOT: state_d = RUN;
      RUN: begin
        if_valid_o = 1'b1;
        if_inst_o  = imem_rdata_i;
        if (id_excp_i && !stall_i && !ex_redirect_i) begin
          state_d = HALT;
          epc_d   = pc_q;
        end
      end
      HALT: if (ex_redirect_i) state_d = RUN;
      default: state_d = BOOT;
    endcase
  end

  assign if_pc_o  = pc_q;
  assign halted_o = (state_q == HALT);
  assign epc_o    = epc_q;

`ifdef FETCH_PERF_EN
  logic [31:0] perf_fetch_q;
  logic [31:0] perf_redirect_q;
  logic        w_fetch_evt;
  logic        w_redir_evt;

  assign w_fetch_evt = if_valid_o && !stall_i;
  assign w_redir_evt = ((state_q == RUN) && (ex_redirect_i || (!stall_i && id_redirect_i)))
                    || ((state_q == HALT) && ex_redirect_i);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_fetch_q    <= '0;
      perf_redirect_q <= '0;
    end else begin
      if (w_fetch_evt && (perf_fetch_q != 32'hFFFF_FFFF))
        perf_fetch_q <= perf_fetch_q + 32'd1;
      if (w_redir_evt && (perf_redirect_q != 32'hFFFF_FFFF))
        perf_redirect_q <= perf_redirect_q + 32'd1;
    end
  end

  assign perf_fetch_o    = perf_fetch_q;
  assign perf_redirect_o = perf_redirect_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_inst_fetch.sv
// ============================================================================
// tb_inst_fetch : scoreboard bench for inst_fetch with a cycle-level reference model
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_inst_fetch;
  import inst_fetch_pkg::*;

  localparam logic [31:0] RST_PC = 32'h0000_0000;

  typedef struct {
    logic        valid;
    logic [31:0] inst;
    logic [31:0] pc;
    logic [31:0] addr;
    logic        halted;
    logic [31:0] epc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall;
  logic        id_redirect;
  logic [31:0] id_target;
  logic        id_excp;
  logic        ex_redirect;
  logic [31:0] ex_target;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic [31:0] if_inst;
  logic [31:0] if_pc;
  logic        if_valid;
  logic        halted;
  logic [31:0] epc;
`ifdef FETCH_PERF_EN
  logic [31:0] perf_fetch;
  logic [31:0] perf_redirect;
`endif

  inst_fetch #(.RESET_PC(RST_PC), .XLEN(32)) dut (
    .clk           (clk),
    .rst           (rst),
    .stall_i       (stall),
    .id_redirect_i (id_redirect),
    .id_target_i   (id_target),
    .id_excp_i     (id_excp),
    .ex_redirect_i (ex_redirect),
    .ex_target_i   (ex_target),
    .imem_addr_o   (imem_addr),
    .imem_rdata_i  (imem_rdata),
    .if_inst_o     (if_inst),
    .if_pc_o       (if_pc),
    .if_valid_o    (if_valid),
    .halted_o      (halted),
    .epc_o         (epc)
`ifdef FETCH_PERF_EN
    ,
    .perf_fetch_o    (perf_fetch),
    .perf_redirect_o (perf_redirect)
`endif
  );

  always #5 clk = ~clk;

  // ROM word at byte address a is its word index.
  function automatic logic [31:0] rom(input logic [31:0] a);
    return {2'b00, a[31:2]};
  endfunction

  always @(posedge clk) imem_rdata <= rom(imem_addr);

  exp_t        q[$];
  int          n_pass  = 0;
  int          n_total = 0;
  int          m_mode  = 0;          // 0 boot, 1 running, 2 halted
  logic [31:0] m_pc    = RST_PC;
  logic [31:0] m_epc   = 32'h0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %08h expected %08h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic cyc(input logic r, input logic st, input logic idr, input logic [31:0] idt,
                     input logic exc, input logic exr, input logic [31:0] ext);
    exp_t        e;
    logic [31:0] nxt;
    int          nmode;
    @(negedge clk);
    #1;
    rst = r; stall = st; id_redirect = idr; id_target = idt;
    id_excp = exc; ex_redirect = exr; ex_target = ext;
    if (r) begin
      m_mode = 0; m_pc = RST_PC; m_epc = 32'h0;
    end
    e.valid  = (m_mode == 1);
    e.inst   = (m_mode == 1) ? rom(m_pc) : NOP_INST;
    e.pc     = m_pc;
    e.halted = (m_mode == 2);
    e.epc    = m_epc;
    nmode    = m_mode;
    if (m_mode == 0) begin
      nxt   = RST_PC;
      nmode = r ? 0 : 1;
    end else if (m_mode == 1) begin
      if (exr)      nxt = ext & ~32'h3;
      else if (st)  nxt = m_pc;
      else if (idr) nxt = idt & ~32'h3;
      else          nxt = m_pc + 32'd4;
      if (exc && !st && !exr) begin
        nmode = 2; m_epc = m_pc;
      end
    end else begin
      nxt = exr ? (ext & ~32'h3) : m_pc;
      if (exr) nmode = 1;
    end
    e.addr = nxt;
    q.push_back(e);
    if (!r) begin
      m_pc   = nxt;
      m_mode = nmode;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, 32'h0, 0, 0, 32'h0);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("valid",  {31'h0, if_valid}, {31'h0, e.valid});
        chk("inst",   if_inst,           e.inst);
        chk("pc",     if_pc,             e.pc);
        chk("addr",   imem_addr,         e.addr);
        chk("halted", {31'h0, halted},   {31'h0, e.halted});
        chk("epc",    epc,               e.epc);
      end
    end
  end

  initial begin : stim
    logic [31:0] t;
    rst = 1'b1; stall = 1'b0; id_redirect = 1'b0; id_target = 32'h0;
    id_excp = 1'b0; ex_redirect = 1'b0; ex_target = 32'h0;

    cyc(1, 0, 0, 32'h0, 0, 0, 32'h0);
    cyc(1, 0, 0, 32'h0, 0, 0, 32'h0);
    idle(3);                                        // BOOT, pc 0, pc 4
    repeat (3) cyc(0, 1, 1, 32'h200, 0, 0, 32'h0);  // stall at pc 8, id redirect ignored
    idle(2);                                        // pc 8, pc C
    cyc(0, 0, 1, 32'h40, 0, 0, 32'h0);              // pc 10 -> 40
    cyc(0, 1, 1, 32'h40, 0, 1, 32'h100);            // ex beats stall and id
    cyc(0, 0, 0, 32'h0, 0, 1, 32'h26);              // unaligned target -> 24
    cyc(0, 0, 0, 32'h0, 1, 0, 32'h0);               // ECALL at 24
    idle(5);
    cyc(0, 0, 0, 32'h0, 0, 1, 32'h80);              // leave HALT
    cyc(0, 0, 0, 32'h0, 1, 1, 32'hFFFF_FFFE);       // wrong-path ECALL discarded
    idle(2);                                        // FFFF_FFFC then wrap to 0
    idle(1);
    cyc(1, 0, 0, 32'h0, 0, 0, 32'h0);               // async reset mid-run
    idle(4);

    for (int i = 0; i < 800; i++) begin
      t = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15))) : $urandom;
      cyc($urandom_range(0, 149) == 0, $urandom_range(0, 3) == 0, $urandom_range(0, 4) == 0,
          $urandom, $urandom_range(0, 11) == 0, $urandom_range(0, 7) == 0, t);
    end
    idle(2);

    repeat (3) @(negedge clk);
    #3;
    n_total++;
    if (q.size() == 0) n_pass++;
    else $display("FAIL drain: got %0d pending expected 0", q.size());

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire
